// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared pipeline widths, register address type and x0 helper
package rv_pipe_pkg;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;
    typedef logic [REG_AW-1:0] reg_addr_t;
    function automatic logic is_x0(input reg_addr_t a);
        return a == '0;
    endfunction
endpackage

// File: rtl/rv_sb_counter.sv
// rv_sb_counter: saturating up/down pending-write counter; underflow flags a decrement at zero
module rv_sb_counter
    import rv_pipe_pkg::*;
#(
    parameter int CNT_W = rv_pipe_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);
    assign underflow = dec & ~inc & ~|cnt;
    always_ff @(posedge clk) begin
        if (!resetn) cnt <= '0;
        else if (inc & ~dec & ~&cnt) cnt <= cnt + 1'b1;
        else if (dec & ~inc & |cnt) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/rv_hazard_scoreboard.sv
// rv_hazard_scoreboard: per-register pending-write scoreboard with RAW/full interlock and stall counter.
// WB_BYPASS_EN: treat a source whose last pending write retires this cycle as ready (write-through regfile).
module rv_hazard_scoreboard
    import rv_pipe_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = rv_pipe_pkg::REG_AW,
    parameter int CNT_W    = rv_pipe_pkg::CNT_W,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_writes_rd,
    input  logic                flush,
    input  logic                wb_retire,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                wb_writes_rd,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [PERF_W-1:0]   stall_cycles,
    output logic                sb_error
);
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_v, dec_v, uf_v, byp_v, eff_busy;
    logic                hazard, full;
    // x0 is never tracked: its counter and strobes are tied off
    assign cnt[0]   = '0;
    assign inc_v[0] = 1'b0;
    assign dec_v[0] = 1'b0;
    assign uf_v[0]  = 1'b0;
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        assign inc_v[i] = issue & id_writes_rd & (id_rd == REG_AW'(i));
        assign dec_v[i] = wb_retire & wb_writes_rd & (wb_rd == REG_AW'(i));
        rv_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .resetn    (resetn),
            .inc       (inc_v[i]),
            .dec       (dec_v[i]),
            .cnt       (cnt[i]),
            .underflow (uf_v[i])
        );
    end
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_busy
        assign busy_vec[i] = |cnt[i];
`ifdef WB_BYPASS_EN
        assign byp_v[i] = dec_v[i] & (cnt[i] == CNT_W'(1));
`else
        assign byp_v[i] = 1'b0;
`endif
    end
    assign eff_busy = busy_vec & ~byp_v;
    assign hazard   = id_valid & ((id_use_rs1 & eff_busy[id_rs1]) | (id_use_rs2 & eff_busy[id_rs2]));
    // a same-cycle retire of rd frees a slot, so a saturated counter does not block
    assign full     = id_valid & id_writes_rd & ~is_x0(reg_addr_t'(id_rd)) & (&cnt[id_rd]) & ~dec_v[id_rd];
    assign stall    = (hazard | full) & ~flush;
    assign issue    = id_valid & ~stall & ~flush;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cycles <= '0;
            sb_error     <= 1'b0;
        end else begin
            if (stall & ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
            if (|uf_v) sb_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rv_hazard_scoreboard.sv
// tb_rv_hazard_scoreboard: directed scoreboard bench for rv_hazard_scoreboard (stall/issue queue + state checks)
module tb_rv_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        resetn, id_valid, id_use_rs1, id_use_rs2, id_writes_rd, flush;
    logic        wb_retire, wb_writes_rd;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        stall, issue, sb_error;
    logic [31:0] busy_vec, stall_cycles;
    int          total = 0, passed = 0, failed = 0, mstall = 0;
    typedef struct {
        string tag;
        logic  stall;
        logic  issue;
    } exp_t;
    exp_t q[$];
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    rv_hazard_scoreboard dut (
        .clk          (clk),
        .resetn       (resetn),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_writes_rd (id_writes_rd),
        .flush        (flush),
        .wb_retire    (wb_retire),
        .wb_rd        (wb_rd),
        .wb_writes_rd (wb_writes_rd),
        .stall        (stall),
        .issue        (issue),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles),
        .sb_error     (sb_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_writes_rd = 0; flush = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        wb_retire = 0; wb_writes_rd = 0; wb_rd = 0;
    endtask

    task automatic id_set(input logic [4:0] rs1, input logic u1, input logic [4:0] rd, input logic w);
        id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rd = rd; id_writes_rd = w;
    endtask

    task automatic ret(input logic [4:0] rd);
        wb_retire = 1; wb_writes_rd = 1; wb_rd = rd;
    endtask

    // inputs are already driven; queue the expectation, compare mid-cycle, then cross the edge
    task automatic step(input string tag, input logic es, input logic ei);
        exp_t e;
        q.push_back('{tag, es, ei});
        @(negedge clk);
        e = q.pop_front();
        chk({e.tag, ".stall"}, 64'(stall), 64'(e.stall));
        chk({e.tag, ".issue"}, 64'(issue), 64'(e.issue));
        if (!resetn) mstall = 0;
        else if (e.stall) mstall++;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        resetn = 0;
        id_set(5, 1, 0, 0);
        step("rst0", 0, 1);
        id_set(5, 1, 0, 0);
        step("rst1", 0, 1);
        chk("rst.busy", 64'(busy_vec), 0);
        chk("rst.scyc", 64'(stall_cycles), 0);
        chk("rst.err", 64'(sb_error), 0);
        resetn = 1;

        id_set(0, 0, 5, 1);
        step("iss5", 0, 1);
        chk("busy5", 64'(busy_vec), 64'h20);
        id_set(5, 1, 0, 0);
        step("raw5a", 1, 0);
        id_set(5, 1, 0, 0);
        step("raw5b", 1, 0);
        id_set(5, 1, 0, 0);
        ret(5);
        step("raw5ret", !BYP, BYP);
        if (!BYP) begin
            id_set(5, 1, 0, 0);
            step("raw5post", 0, 1);
        end
        chk("raw.scyc", 64'(stall_cycles), 64'(mstall));
        chk("raw.busy", 64'(busy_vec), 0);

        id_set(0, 1, 0, 1);
        id_use_rs2 = 1;
        step("x0a", 0, 1);
        id_set(0, 1, 0, 1);
        step("x0b", 0, 1);
        chk("x0.busy", 64'(busy_vec), 0);

        for (int k = 0; k < 3; k++) begin
            id_set(0, 0, 7, 1);
            step($sformatf("iss7_%0d", k), 0, 1);
        end
        chk("busy7", 64'(busy_vec), 64'h80);
        id_set(0, 0, 7, 1);
        step("full7", 1, 0);
        id_set(0, 0, 7, 1);
        ret(7);
        step("full7ret", 0, 1);
        chk("full.scyc", 64'(stall_cycles), 64'(mstall));
        for (int k = 0; k < 3; k++) begin
            ret(7);
            step($sformatf("drain7_%0d", k), 0, 0);
        end
        chk("drain.busy", 64'(busy_vec), 0);
        chk("drain.err", 64'(sb_error), 0);

        id_set(0, 0, 3, 1);
        step("iss3", 0, 1);
        id_set(3, 1, 4, 1);
        flush = 1;
        step("flush", 0, 0);
        chk("flush.busy", 64'(busy_vec), 64'h08);
        id_set(3, 1, 4, 1);
        step("raw3", 1, 0);
        ret(3);
        step("ret3", 0, 0);
        chk("flush.scyc", 64'(stall_cycles), 64'(mstall));
        chk("flush.busy0", 64'(busy_vec), 0);

        ret(9);
        step("uf9", 0, 0);
        chk("uf.err", 64'(sb_error), 1);
        id_set(0, 0, 2, 1);
        step("iss2", 0, 1);
        ret(2);
        step("ret2", 0, 0);
        chk("uf.hold", 64'(sb_error), 1);
        chk("uf.busy", 64'(busy_vec), 0);
        resetn = 0;
        step("rst2", 0, 0);
        chk("rst2.err", 64'(sb_error), 0);
        chk("rst2.scyc", 64'(stall_cycles), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
